// File: rtl/booth_mult_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier.
// Holds the FSM state encoding, Booth digit codes and the iteration-count helper.
package booth_mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } booth_state_e;

    typedef enum logic [2:0] {
        BD_ZERO = 3'd0,
        BD_P1   = 3'd1,
        BD_P2   = 3'd2,
        BD_M1   = 3'd3,
        BD_M2   = 3'd4
    } booth_digit_e;

    // One radix-4 digit per bit pair of the (WIDTH+2)-bit extended multiplier.
    function automatic int iter_of(input int width);
        return width / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth recoder: turns a multiplier bit triple into a digit and
// forms the matching signed partial product from the extended multiplicand.
module booth_r4_enc
    import booth_mult_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [2:0]       triple,
    input  logic [WIDTH+1:0] m,
    output logic [WIDTH+3:0] pp
);

    booth_digit_e     digit;
    logic [WIDTH+3:0] m_ext;

    assign m_ext = {{2{m[WIDTH+1]}}, m};

    always_comb begin
        digit = BD_ZERO;
        case (triple)
            3'b001, 3'b010: digit = BD_P1;
            3'b011:         digit = BD_P2;
            3'b100:         digit = BD_M2;
            3'b101, 3'b110: digit = BD_M1;
            default:        digit = BD_ZERO;
        endcase
    end

    always_comb begin
        pp = '0;
        case (digit)
            BD_P1:   pp = m_ext;
            BD_P2:   pp = m_ext << 1;
            BD_M1:   pp = -m_ext;
            BD_M2:   pp = -(m_ext << 1);
            default: pp = '0;
        endcase
    end

endmodule

// File: rtl/booth_mult_r4.sv
// Sequential radix-4 Booth multiplier with start/busy/ready handshake.
// Fixed latency of ITER cycles; the product register holds until the next completion.
module booth_mult_r4
    import booth_mult_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               ready,
    output logic [2*WIDTH-1:0] c
);

    localparam int ITER = iter_of(WIDTH);
    localparam int CW   = $clog2(ITER);
    localparam int AW   = 2 * WIDTH + 4;

    booth_state_e     state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [WIDTH+1:0] m_q, m_d;
    logic [WIDTH+2:0] b_q, b_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    logic [2*WIDTH-1:0] c_q, c_d;

    logic [WIDTH+3:0] pp;
    logic [AW-1:0]    pp_aligned;
    logic [AW-1:0]    acc_sum;
    logic [AW-1:0]    acc_shr;
    logic             last_step;

    booth_r4_enc #(.WIDTH(WIDTH)) u_enc (
        .triple (b_q[2:0]),
        .m      (m_q),
        .pp     (pp)
    );

    // Partial products enter at bit WIDTH+2 so that after ITER shifts of two
    // the first one lands at bit 0; the running sum always fits AW signed bits.
    assign pp_aligned = {{WIDTH{pp[WIDTH+3]}}, pp} << (WIDTH + 2);
    assign acc_sum    = acc_q + pp_aligned;
    assign acc_shr    = {{2{acc_sum[AW-1]}}, acc_sum[AW-1:2]};
    assign last_step  = (cnt_q == CW'(ITER - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        m_d     = m_q;
        b_d     = b_q;
        busy_d  = busy_q;
        ready_d = ready_q;
        c_d     = c_q;
        case (state_q)
            ST_RUN: begin
                acc_d = acc_shr;
                b_d   = b_q >> 2;
                cnt_d = cnt_q + 1'b1;
                if (last_step) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                    cnt_d   = '0;
                    c_d     = acc_shr[2*WIDTH-1:0];
                end
            end
            default: begin
                if (start) begin
                    state_d = ST_RUN;
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                    cnt_d   = '0;
                    acc_d   = '0;
                    m_d     = {{2{signed_mode & a[WIDTH-1]}}, a};
                    b_d     = {{2{signed_mode & b[WIDTH-1]}}, b, 1'b0};
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            m_q     <= '0;
            b_q     <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            m_q     <= m_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            c_q     <= c_d;
        end
    end

    assign busy  = busy_q;
    assign ready = ready_q;
    assign c     = c_q;

endmodule
